// File: rtl/viterbi_link_pkg.sv
// viterbi_link_pkg: shared states, LFSR constants and helpers for the link sequencer
package viterbi_link_pkg;
    typedef enum logic [2:0] {IDLE, RUN, FLUSH, DRAIN, DONE} state_t;
    // Fibonacci taps 16,14,13,11 on a right-shifting register map to bits 0,2,3,5
    localparam logic [15:0] LFSR_TAPS = 16'h002D;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {^(l & LFSR_TAPS), l[15:1]};
    endfunction
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
endpackage

// File: rtl/viterbi_link_sequencer_ref_delay.sv
// viterbi_ref_delay: LAT-deep {valid,bit} shift register aligning source bits with decoder output
module viterbi_ref_delay #(
    parameter int LAT = 40
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic in_vld,
    input  logic in_bit,
    output logic out_vld,
    output logic out_bit
);
    logic [LAT-1:0] vld_sr, bit_sr;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_sr <= '0;
            bit_sr <= '0;
        end else if (clr) begin
            vld_sr <= '0;
            bit_sr <= '0;
        end else begin
            vld_sr <= {vld_sr[LAT-2:0], in_vld};
            bit_sr <= {bit_sr[LAT-2:0], in_bit};
        end
    end
    assign out_vld = vld_sr[LAT-1];
    assign out_bit = bit_sr[LAT-1];
endmodule

// File: rtl/viterbi_link_sequencer.sv
// viterbi_link_sequencer: run controller for encoder -> burst channel -> Viterbi decoder link tests
module viterbi_link_sequencer
    import viterbi_link_pkg::*;
#(
    parameter int FRAME_LEN  = 256,
    parameter int TAIL_LEN   = 8,
    parameter int LAT        = 40,
    parameter int BURST_LOG2 = 5,
    parameter int BURST_LEN  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [15:0] seed_i,
    input  logic        burst_en_i,
    output logic        enc_bit_o,
    output logic        enc_en_o,
    input  logic [1:0]  enc_sym_i,
    input  logic        enc_vld_i,
    output logic [1:0]  chan_sym_o,
    output logic        dec_en_o,
    input  logic        dec_bit_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] bit_err_ct_o,
    output logic [15:0] inj_ct_o
);
    localparam logic [BURST_LOG2-1:0] THR = BURST_LOG2'((2**BURST_LOG2) - BURST_LEN);
    state_t      state_q, state_d;
    logic [15:0] cnt, lfsr;
    logic        burst_q, inj_q, accept, ref_vld, ref_bit;
    assign accept    = start_i && (state_q == IDLE);
    assign busy_o    = state_q inside {RUN, FLUSH, DRAIN};
    assign enc_en_o  = state_q inside {RUN, FLUSH};
    assign enc_bit_o = (state_q == RUN) && lfsr[0];
    assign done_o    = state_q == DONE;
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  state_d = start_i ? RUN : IDLE;
            RUN:   state_d = (cnt == 16'(FRAME_LEN - 1)) ? FLUSH : RUN;
            FLUSH: state_d = (cnt == 16'(TAIL_LEN - 1)) ? DRAIN : FLUSH;
            DRAIN: state_d = (cnt == 16'(LAT - 1)) ? DONE : DRAIN;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt          <= '0;
            lfsr         <= '0;
            burst_q      <= 1'b0;
            inj_q        <= 1'b0;
            chan_sym_o   <= '0;
            dec_en_o     <= 1'b0;
            bit_err_ct_o <= '0;
            inj_ct_o     <= '0;
        end else begin
            state_q  <= state_d;
            cnt      <= (state_d != state_q || state_q == IDLE) ? '0 : cnt + 16'd1;
            lfsr     <= accept ? ((seed_i == 16'd0) ? DEFAULT_SEED : seed_i)
                      : (state_q == RUN) ? lfsr_step(lfsr) : lfsr;
            burst_q  <= accept ? burst_en_i : burst_q;
            // one-cycle hold matches the registered encoder so the flag meets its own symbol
            inj_q    <= (state_q == RUN) && burst_q && (BURST_LEN != 0) && (cnt[BURST_LOG2-1:0] >= THR);
            chan_sym_o <= enc_sym_i ^ {inj_q && enc_vld_i, 1'b0};
            dec_en_o <= enc_vld_i;
            inj_ct_o <= accept ? '0 : (inj_q && enc_vld_i) ? sat_inc(inj_ct_o) : inj_ct_o;
            bit_err_ct_o <= accept ? '0
                          : (ref_vld && (ref_bit != dec_bit_i)) ? sat_inc(bit_err_ct_o) : bit_err_ct_o;
        end
    end
    viterbi_ref_delay #(.LAT(LAT)) u_ref (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .in_vld  (state_q == RUN),
        .in_bit  (enc_bit_o),
        .out_vld (ref_vld),
        .out_bit (ref_bit)
    );
endmodule

// File: tb/tb_viterbi_link_sequencer.sv
// tb_viterbi_link_sequencer: table-driven runs with a channel-symbol scoreboard and stub encoder/decoder
module tb_viterbi_link_sequencer;
    localparam int FRAME = 256;
    localparam int TAIL  = 8;
    localparam int LAT   = 40;

    typedef struct {
        logic [15:0] seed;
        bit          burst;
        int          inv;
        int          exp_err;
        int          exp_inj;
        bit          mid;
    } vec_t;

    logic        clk = 1'b0, rst = 1'b0, start_i = 1'b0, burst_en_i = 1'b0;
    logic [15:0] seed_i = '0;
    logic        enc_bit_o, enc_en_o, dec_en_o, busy_o, done_o;
    logic [1:0]  chan_sym_o;
    logic [15:0] bit_err_ct_o, inj_ct_o;
    logic [1:0]  enc_st, enc_sym;
    logic        enc_vld;
    logic [LAT-1:0] dsr;
    int          enc_idx, tb_idx;
    int          inv_idx = -1;
    bit          cur_burst = 1'b0;
    int          n_cmp = 0, n_err = 0;
    logic [1:0]  sbq[$];
    vec_t        tbl[8];

    always #5 clk = ~clk;

    viterbi_link_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .seed_i       (seed_i),
        .burst_en_i   (burst_en_i),
        .enc_bit_o    (enc_bit_o),
        .enc_en_o     (enc_en_o),
        .enc_sym_i    (enc_sym),
        .enc_vld_i    (enc_vld),
        .chan_sym_o   (chan_sym_o),
        .dec_en_o     (dec_en_o),
        .dec_bit_i    (dsr[LAT-1]),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .bit_err_ct_o (bit_err_ct_o),
        .inj_ct_o     (inj_ct_o)
    );

    // K=3 (7,5) registered encoder and a LAT-delay stub decoder with one selectable inverted bit
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            enc_st  <= '0;
            enc_sym <= '0;
            enc_vld <= 1'b0;
            enc_idx <= 0;
            tb_idx  <= 0;
            dsr     <= '0;
        end else begin
            enc_vld <= enc_en_o;
            if (enc_en_o) begin
                enc_sym <= {enc_bit_o ^ enc_st[1] ^ enc_st[0], enc_bit_o ^ enc_st[0]};
                enc_st  <= {enc_bit_o, enc_st[1]};
                enc_idx <= tb_idx;
            end else if (!busy_o) begin
                enc_st <= '0;
            end
            tb_idx <= enc_en_o ? tb_idx + 1 : (busy_o ? tb_idx : 0);
            dsr    <= {dsr[LAT-2:0], enc_bit_o ^ (enc_en_o && tb_idx == inv_idx)};
        end
    end

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sb_step();
        logic [1:0] e;
        if (dec_en_o) begin
            if (sbq.size() == 0) begin
                check("chan_sym_unexpected", 32'(dec_en_o), 32'd0);
            end else begin
                e = sbq.pop_front();
                check("chan_sym", 32'(chan_sym_o), 32'(e));
            end
        end
        if (enc_vld)
            sbq.push_back(enc_sym ^ {cur_burst && enc_idx < FRAME && (enc_idx % 32) >= 28, 1'b0});
    endtask

    task automatic tick();
        @(negedge clk);
        sb_step();
    endtask

    task automatic run_one(input vec_t v);
        logic [15:0] m;
        int          n;
        bit          seen;
        m = (v.seed == 16'd0) ? 16'hACE1 : v.seed;
        inv_idx = v.inv;
        seed_i = v.seed;
        burst_en_i = v.burst;
        cur_burst = v.burst;
        start_i = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 400) begin
            tick();
            n++;
            start_i = v.mid && n == 50;
            if (v.mid && n == 50) begin
                seed_i = 16'h0F0F;
                burst_en_i = ~v.burst;
            end
            if (n == 1) check("busy_enc_en_start", 32'({busy_o, enc_en_o}), 32'h3);
            if (n <= FRAME) begin
                check("enc_bit", 32'(enc_bit_o), 32'(m[0]));
                m = lfsr_next(m);
            end
            if (done_o) begin
                seen = 1'b1;
                check("done_cycle", n, 1 + FRAME + TAIL + LAT);
                check("busy_in_done", 32'(busy_o), 32'd0);
                check("bit_err_ct", 32'(bit_err_ct_o), v.exp_err);
                check("inj_ct", 32'(inj_ct_o), v.exp_inj);
            end
        end
        if (!seen) check("done_timeout", n, 1 + FRAME + TAIL + LAT);
        tick();
        check("done_pulse_width", 32'(done_o), 32'd0);
        check("counts_hold", 32'({bit_err_ct_o, inj_ct_o}), (v.exp_err << 16) | v.exp_inj);
        check("scoreboard_drained", sbq.size(), 0);
    endtask

    initial begin
        tbl[0] = '{16'h1234, 1'b0, -1,  0, 0,  1'b0};
        tbl[1] = '{16'h0000, 1'b1, -1,  0, 32, 1'b0};
        tbl[2] = '{16'h1234, 1'b0, 100, 1, 0,  1'b0};
        tbl[3] = '{16'h1234, 1'b0, 260, 0, 0,  1'b0};
        tbl[4] = '{16'hACE1, 1'b0, 0,   1, 0,  1'b0};
        tbl[5] = '{16'hBEEF, 1'b1, 255, 1, 32, 1'b0};
        tbl[6] = '{16'h5A5A, 1'b1, 17,  1, 32, 1'b1};
        tbl[7] = '{16'h1234, 1'b0, 256, 0, 0,  1'b0};
        repeat (3) tick();
        check("reset_outputs", 32'({enc_bit_o, enc_en_o, chan_sym_o, dec_en_o, busy_o, done_o}), 32'd0);
        check("reset_counts", 32'({bit_err_ct_o, inj_ct_o}), 32'd0);
        rst = 1'b1;
        tick();
        foreach (tbl[i]) run_one(tbl[i]);
        // asynchronous reset 120 cycles into a burst run, then a clean rerun
        inv_idx = -1;
        cur_burst = 1'b1;
        seed_i = 16'h1234;
        burst_en_i = 1'b1;
        start_i = 1'b1;
        repeat (120) begin
            tick();
            start_i = 1'b0;
        end
        check("inj_mid_run", 32'(inj_ct_o), 32'd12);
        #2 rst = 1'b0;
        #1;
        check("async_rst_outputs", 32'({enc_bit_o, enc_en_o, chan_sym_o, dec_en_o, busy_o, done_o}), 32'd0);
        check("async_rst_counts", 32'({bit_err_ct_o, inj_ct_o}), 32'd0);
        sbq.delete();
        tick();
        tick();
        check("held_in_reset", 32'({busy_o, done_o, enc_en_o}), 32'd0);
        rst = 1'b1;
        tick();
        run_one('{16'h1234, 1'b1, 100, 1, 32, 1'b0});
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
